// File: rtl/delay_timer.sv
// delay_timer: periodic tick-based delay timer emitting a one-clock pulse per period
module delay_timer #(
   parameter int TICK_DIV = 1,
   parameter int CNT_W    = 9,
   parameter int PRE_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] delay,
   output logic             out_delay
);
   typedef enum logic {IDLE, COUNT} state_t;
   state_t state, state_n;
   logic [PRE_W-1:0] pre, pre_n;
   logic [CNT_W-1:0] cnt, cnt_n, period, period_n;
   logic out_n, tick, expire;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         pre       <= '0;
         cnt       <= '0;
         period    <= '0;
         out_delay <= 1'b0;
      end else begin
         state     <= state_n;
         pre       <= pre_n;
         cnt       <= cnt_n;
         period    <= period_n;
         out_delay <= out_n;
      end
   end
   // period is only sampled on entry and at expiry, so mid-count delay changes wait for the reload
   always_comb begin
      tick     = state == COUNT && pre == PRE_W'(TICK_DIV - 1);
      expire   = tick && cnt == period - CNT_W'(1);
      state_n  = state;
      pre_n    = pre;
      cnt_n    = cnt;
      period_n = period;
      out_n    = 1'b0;
      if (state == IDLE) begin
         if (delay != '0) begin
            period_n = delay;
            cnt_n    = '0;
            pre_n    = '0;
            state_n  = COUNT;
         end
      end else begin
         pre_n = tick ? '0 : pre + PRE_W'(1);
         if (expire) begin
            cnt_n    = '0;
            out_n    = 1'b1;
            period_n = delay;
            state_n  = delay == '0 ? IDLE : COUNT;
         end else if (tick) begin
            cnt_n = cnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_delay_timer.sv
// tb_delay_timer: scoreboard bench; expected pulse cycles are queued at stimulus time
module tb_delay_timer;
   logic clk = 1'b0;
   logic rst_a = 1'b0, rst_b = 1'b0;
   logic [8:0] delay_a = '0, delay_b = '0;
   logic out_delay_a, out_delay_b;
   int cyc = 0;
   int n_checks = 0, n_fail = 0;
   int qa[$], qb[$];
   bit ea, eb;

   delay_timer dut_a (.clk(clk), .rst(rst_a), .delay(delay_a), .out_delay(out_delay_a));
   delay_timer #(.TICK_DIV(4)) dut_b (.clk(clk), .rst(rst_b), .delay(delay_b), .out_delay(out_delay_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // cyc = index of the last rising edge; a pulse launched by edge N is expected at cyc N
   always @(negedge clk) begin
      ea = qa.size() > 0 && qa[0] == cyc;
      if (ea) void'(qa.pop_front());
      eb = qb.size() > 0 && qb[0] == cyc;
      if (eb) void'(qb.pop_front());
      n_checks += 2;
      if (out_delay_a !== ea) begin
         n_fail++;
         $display("FAIL pulse_a cyc=%0d out_delay=%b expected=%b", cyc, out_delay_a, ea);
      end
      if (out_delay_b !== eb) begin
         n_fail++;
         $display("FAIL pulse_b cyc=%0d out_delay=%b expected=%b", cyc, out_delay_b, eb);
      end
   end

   task automatic start_a(input logic [8:0] d, output int e0);
      @(negedge clk);
      delay_a = d;
      rst_a = 1'b1;
      e0 = cyc + 1;
   endtask

   task automatic stop_a();
      rst_a = 1'b0;
      delay_a = '0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      delay_a = 9'd60;
      repeat (2) begin
         @(negedge clk);
         n_checks++;
         if (out_delay_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold out_delay=%b expected=0", out_delay_a);
         end
      end
      stop_a();
   endtask

   task automatic test_basic();
      int e0, np;
      np = 0;
      start_a(9'd60, e0);
      for (int k = 1; k <= 4; k++) qa.push_back(e0 + 60 * k);
      repeat (245) begin
         @(negedge clk);
         if (cyc < e0 + 59) begin
            n_checks++;
            if (out_delay_a !== 1'b0) begin
               n_fail++;
               $display("FAIL early_pulse cyc=%0d out_delay=%b expected=0", cyc, out_delay_a);
            end
         end
         if (out_delay_a) np++;
      end
      stop_a();
      n_checks += 2;
      if (np !== 4) begin
         n_fail++;
         $display("FAIL basic_count pulses=%0d expected=4", np);
      end
      if (qa.size() !== 0) begin
         n_fail++;
         $display("FAIL basic_drain pending=%0d expected=0", qa.size());
      end
   endtask

   task automatic test_midchange();
      int e0;
      start_a(9'd60, e0);
      qa.push_back(e0 + 60);
      repeat (31) @(negedge clk);
      delay_a = 9'd20;
      for (int k = 1; k <= 3; k++) qa.push_back(e0 + 60 + 20 * k);
      repeat (95) @(negedge clk);
      stop_a();
      n_checks++;
      if (qa.size() !== 0) begin
         n_fail++;
         $display("FAIL midchange_drain pending=%0d expected=0", qa.size());
      end
   endtask

   task automatic test_disable();
      int e0, e1;
      start_a(9'd60, e0);
      qa.push_back(e0 + 60);
      repeat (41) @(negedge clk);
      delay_a = '0;
      repeat (40) @(negedge clk);
      n_checks++;
      if (out_delay_a !== 1'b0 || qa.size() !== 0) begin
         n_fail++;
         $display("FAIL disable_idle out_delay=%b pending=%0d expected=0/0", out_delay_a, qa.size());
      end
      delay_a = 9'd5;
      e1 = cyc + 1;
      for (int k = 1; k <= 4; k++) qa.push_back(e1 + 5 * k);
      repeat (23) @(negedge clk);
      stop_a();
      n_checks++;
      if (qa.size() !== 0) begin
         n_fail++;
         $display("FAIL disable_reload pending=%0d expected=0", qa.size());
      end
   endtask

   task automatic test_edges();
      int e0;
      start_a(9'd1, e0);
      for (int k = 1; k <= 19; k++) qa.push_back(e0 + k);
      @(negedge clk);
      repeat (19) begin
         @(negedge clk);
         n_checks++;
         if (out_delay_a !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back cyc=%0d out_delay=%b expected=1", cyc, out_delay_a);
         end
      end
      stop_a();
      start_a(9'd511, e0);
      qa.push_back(e0 + 511);
      qa.push_back(e0 + 1022);
      repeat (1031) @(negedge clk);
      stop_a();
      n_checks++;
      if (qa.size() !== 0) begin
         n_fail++;
         $display("FAIL max_period pending=%0d expected=0", qa.size());
      end
   endtask

   task automatic test_prescaler();
      int e0, e1;
      @(negedge clk);
      delay_b = 9'd3;
      rst_b = 1'b1;
      e0 = cyc + 1;
      qb.push_back(e0 + 12);
      qb.push_back(e0 + 24);
      repeat (31) @(negedge clk);
      rst_b = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_delay_b !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset out_delay=%b expected=0", out_delay_b);
      end
      rst_b = 1'b1;
      e1 = cyc + 1;
      qb.push_back(e1 + 12);
      qb.push_back(e1 + 24);
      repeat (26) @(negedge clk);
      rst_b = 1'b0;
      delay_b = '0;
      @(negedge clk);
      n_checks++;
      if (qb.size() !== 0) begin
         n_fail++;
         $display("FAIL prescaler_drain pending=%0d expected=0", qb.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_midchange();
      test_disable();
      test_edges();
      test_prescaler();
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
